// File: rtl/l3_req_arbiter.sv
// Round-robin arbiter sharing one single-ported L3 among NUM_REQ requesters, one transaction
// in flight. Optional WAIT-state watchdog enabled by defining L3_ARB_TIMEOUT_EN.
module l3_req_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ID_W           = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_write,
   input  logic [NUM_REQ*32-1:0]   req_addr,
   input  logic [NUM_REQ*32-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      req_ack,
   output logic [NUM_REQ-1:0]      resp_valid,
   output logic [31:0]             resp_rdata,
   output logic                    resp_err,
   output logic                    busy,
   output logic                    l3_valid,
   output logic                    l3_read,
   output logic                    l3_write,
   output logic [31:0]             l3_addr,
   output logic [31:0]             l3_write_word,
   input  logic [31:0]             l3_read_word,
   input  logic                    l3_ready
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1)
   begin : g_param_check
      $error("l3_req_arbiter: invalid parameter combination");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            r_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_gnt;
   logic              r_write;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata_hold;

   logic              w_found;
   logic [ID_W-1:0]   w_gnt;
   logic [ID_W-1:0]   w_idx;
   logic              w_cmd;
   logic              w_err;

`ifdef L3_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0]   r_cnt;
   logic              r_err;
   assign w_err = r_err;
`else
   assign w_err = 1'b0;
`endif

   // First requesting index at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = w_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= StIdle;
         r_rr_ptr     <= '0;
         r_gnt        <= '0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata_hold <= '0;
`ifdef L3_ARB_TIMEOUT_EN
         r_cnt        <= '0;
         r_err        <= 1'b0;
`endif
      end else begin
         case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_gnt   <= w_gnt;
                  r_write <= req_write[w_gnt];
                  r_addr  <= req_addr[32*w_gnt +: 32];
                  r_wdata <= req_wdata[32*w_gnt +: 32];
                  r_state <= StIssue;
               end
            end
            StIssue: begin
`ifdef L3_ARB_TIMEOUT_EN
               r_cnt   <= '0;
               r_err   <= 1'b0;
`endif
               r_state <= StWait;
            end
            StWait: begin
               // The final not-ready cycle is the L3 hit cycle, so the last capture wins.
               if (!l3_ready) r_rdata_hold <= l3_read_word;
               if (l3_ready) r_state <= StResp;
`ifdef L3_ARB_TIMEOUT_EN
               else if (r_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                  r_err   <= 1'b1;
                  r_state <= StResp;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
`endif
            end
            StResp: begin
               r_rr_ptr <= (r_gnt == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt + ID_W'(1);
               r_state  <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_comb begin
      req_ack = '0;
      if (r_state == StIdle && w_found && !reset) req_ack[w_gnt] = 1'b1;
      resp_valid = '0;
      if (r_state == StResp) resp_valid[r_gnt] = 1'b1;
   end

   assign w_cmd         = (r_state == StIssue) || (r_state == StWait);
   assign busy          = (r_state != StIdle);
   assign l3_valid      = (r_state == StIssue);
   assign l3_read       = w_cmd & ~r_write;
   assign l3_write      = w_cmd & r_write;
   assign l3_addr       = w_cmd ? r_addr : '0;
   assign l3_write_word = w_cmd ? r_wdata : '0;
   assign resp_err      = (r_state == StResp) & w_err;
   assign resp_rdata    = (r_state == StResp && !r_write && !w_err) ? r_rdata_hold : '0;

endmodule

// File: tb/tb_l3_req_arbiter.sv
// Scoreboard bench for l3_req_arbiter with a behavioural L3 (hit / clean miss / dirty miss / stuck).
module tb_l3_req_arbiter;

   localparam int NR = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid, req_write, req_ack, resp_valid;
   logic [NR*32-1:0]  req_addr, req_wdata;
   logic [31:0]       resp_rdata, l3_addr, l3_write_word, l3_read_word;
   logic              resp_err, busy, l3_valid, l3_read, l3_write, l3_ready;

   l3_req_arbiter #(.NUM_REQ(NR), .ID_W(2), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy), .l3_valid(l3_valid),
      .l3_read(l3_read), .l3_write(l3_write), .l3_addr(l3_addr),
      .l3_write_word(l3_write_word), .l3_read_word(l3_read_word), .l3_ready(l3_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  lat;
   } exp_t;

   exp_t sb_q[$];
   int   ack_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural L3: ready drops for lat cycles after a strobe; correct word only in the last one.
   logic [31:0] mem [logic [31:0]];
   logic [31:0] m_addr;
   int          m_cnt;

   function automatic int lat_of(input logic [31:0] a);
      if (a[31:28] == 4'hF) return 1000;
      if (a[13]) return 4;
      if (a[12]) return 3;
      return 1;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt  <= 0;
         m_addr <= '0;
      end else if (l3_valid) begin
         m_cnt  <= lat_of(l3_addr);
         m_addr <= l3_addr;
         if (l3_write) mem[l3_addr] = l3_write_word;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
      end
   end

   assign l3_ready     = (m_cnt == 0);
   assign l3_read_word = (m_cnt == 1) ? mem_rd(m_addr) : (32'hBAD0_0000 | 32'(m_cnt));

   // Monitor: pops expected acks/responses and checks latency, strobe count, address stability.
   int          cyc = 0;
   int          ack_cyc = 0;
   int          v_cnt = 0;
   logic        addr_bad = 1'b0;
   logic [31:0] iss_addr = '0;

   initial begin
      exp_t e;
      int   a;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            v_cnt    = 0;
            addr_bad = 1'b0;
         end else begin
            if (req_ack != 0) begin
               if (ack_q.size() == 0) begin
                  chk("unexpected_ack", 32'(req_ack), 32'h0);
               end else begin
                  a = ack_q.pop_front();
                  chk("req_ack", 32'(req_ack), 32'(1) << a);
                  ack_cyc  = cyc;
                  v_cnt    = 0;
                  addr_bad = 1'b0;
               end
            end
            if (l3_valid) begin
               v_cnt++;
               iss_addr = l3_addr;
            end else if (v_cnt > 0 && busy && resp_valid == 0 && l3_addr !== iss_addr) begin
               addr_bad = 1'b1;
            end
            if (resp_valid != 0) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_resp", 32'(resp_valid), 32'h0);
               end else begin
                  e = sb_q.pop_front();
                  chk("resp_valid", 32'(resp_valid), 32'(1) << e.id);
                  chk("resp_rdata", resp_rdata, e.rdata);
                  chk("resp_err", 32'(resp_err), 32'(e.err));
                  chk("latency", 32'(cyc - ack_cyc), 32'(e.lat));
                  chk("l3_valid_pulses", 32'(v_cnt), 32'd1);
                  chk("l3_addr_stable", 32'(addr_bad), 32'd0);
               end
            end
         end
      end
   end

   task automatic issue(input int id, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input logic err,
                        input int lat);
      req_write[id]          = wr;
      req_addr[32*id +: 32]  = addr;
      req_wdata[32*id +: 32] = wd;
      req_valid[id]          = 1'b1;
      ack_q.push_back(id);
      sb_q.push_back('{id: 2'(id), rdata: rd, err: err, lat: 8'(lat)});
   endtask

   // Requesters drop req_valid after their ack; drop_mask requesters give up after drop_at cycles.
   task automatic wait_done(input int budget, input logic [NR-1:0] drop_mask, input int drop_at);
      int            n = 0;
      logic [NR-1:0] acked;
      while ((req_valid != 0 || sb_q.size() != 0) && n < budget) begin
         @(negedge clk);
         acked = req_ack;
         @(posedge clk);
         #1;
         req_valid = req_valid & ~acked;
         n++;
         if (n == drop_at) req_valid = req_valid & ~drop_mask;
      end
      chk("wait_done_budget", 32'(n >= budget), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [NR-1:0] acked;
      reset     = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      mem[32'h0000_0040] = 32'hDEAD_BEEF;
      mem[32'h0000_0204] = 32'h2222_0204;
      mem[32'h0000_1080] = 32'hCAFE_0001;
      mem[32'h0000_2010] = 32'h5A5A_A5A5;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_l3_valid", 32'(l3_valid), 32'd0);
      chk("rst_l3_addr", l3_addr, 32'd0);
      chk("rst_req_ack", 32'(req_ack), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      reset = 1'b0;

      // Single read hit, then write and read-back by one requester.
      issue(1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);
      wait_done(40, '0, 0);
      issue(0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0, 4);
      wait_done(40, '0, 0);
      issue(0, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 1'b0, 4);
      wait_done(40, '0, 0);

      // Reset while in WAIT of a clean miss: outputs clear at once, no response ever appears.
      req_write[2]         = 1'b0;
      req_addr[64 +: 32]   = 32'h0000_1080;
      req_valid[2]         = 1'b1;
      ack_q.push_back(2);
      @(negedge clk);
      acked = req_ack;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acked;
      repeat (2) @(posedge clk);
      #1;
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_l3_read", 32'(l3_read), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_l3_read", 32'(l3_read), 32'd0);
      chk("async_rst_l3_addr", l3_addr, 32'd0);
      chk("async_rst_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;

      // All four at once from reset, then 0 and 2 together after the 3->0 wrap.
      issue(0, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);
      issue(1, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 1'b0, 4);
      issue(2, 1'b0, 32'h0000_0204, 32'h0, 32'h2222_0204, 1'b0, 4);
      issue(3, 1'b0, 32'h0000_0308, 32'h0, 32'h0000_0000, 1'b0, 4);
      wait_done(100, '0, 0);
      issue(0, 1'b1, 32'h0000_0308, 32'hA5A5_0308, 32'h0, 1'b0, 4);
      issue(2, 1'b0, 32'h0000_0308, 32'h0, 32'hA5A5_0308, 1'b0, 4);
      wait_done(60, '0, 0);

      // Clean miss, then dirty miss while requester 3 gives up before being granted.
      issue(3, 1'b0, 32'h0000_1080, 32'h0, 32'hCAFE_0001, 1'b0, 6);
      wait_done(40, '0, 0);
      issue(1, 1'b0, 32'h0000_2010, 32'h0, 32'h5A5A_A5A5, 1'b0, 7);
      req_write[3]       = 1'b0;
      req_addr[96 +: 32] = 32'h0000_0040;
      req_valid[3]       = 1'b1;
      wait_done(60, 4'b1000, 3);

`ifdef L3_ARB_TIMEOUT_EN
      // L3 never becomes ready: 8 WAIT cycles then an error response.
      issue(2, 1'b0, 32'hF000_0000, 32'h0, 32'h0, 1'b1, 10);
      wait_done(60, '0, 0);
      chk("busy_after_timeout", 32'(busy), 32'd0);
`endif

      chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/l3_req_arbiter.md
Name: l3_req_arbiter

Overview:
- Shares the single-ported shared L3 cache between NUM_REQ requesters (L2 controllers or cores).
- Round-robin arbitration; one L3 transaction in flight at a time.
- Drives the L3 word interface (valid/read/write/Addr/write_word) and holds address and command stable for the whole transaction.
- Returns read data and a completion pulse to the granted requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant index, equals clog2(NUM_REQ)
TIMEOUT_CYCLES, 64, watchdog limit in WAIT state (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request; held until req_ack
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*32  request byte addresses; requester i uses bits [32i+31:32i]
req_wdata  in  NUM_REQ*32  request write words; same packing as req_addr
req_ack  out  NUM_REQ  one-hot 1-cycle pulse: request accepted
resp_valid  out  NUM_REQ  one-hot 1-cycle pulse: transaction complete
resp_rdata  out  32  read word, valid with resp_valid; 0 for writes
resp_err  out  1  timeout flag, valid with resp_valid
busy  out  1  high in every state except IDLE
l3_valid  out  1  L3 request strobe
l3_read  out  1  L3 read command
l3_write  out  1  L3 write command
l3_addr  out  32  L3 address
l3_write_word  out  32  L3 write data
l3_read_word  in  32  L3 read data
l3_ready  in  1  L3 idle indication

Behaviour:
- Reset (async, active-high): state = IDLE, rr_ptr = 0, all outputs and holding registers = 0. Any in-flight transaction is dropped and no resp_valid is issued. The L3 is reset by the same signal.
- State IDLE:
  - If any req_valid bit is set, grant the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Latch grant index g, write flag, address and write data.
  - Pulse req_ack[g] in this cycle; next state = ISSUE.
  - Otherwise stay in IDLE.
- State ISSUE:
  - l3_valid = 1 for exactly this cycle.
  - l3_valid must not depend combinationally on l3_ready; L3 is guaranteed idle on entry.
  - Next state = WAIT.
- State WAIT:
  - l3_valid = 0.
  - Each cycle with l3_ready = 0: rdata_hold <= l3_read_word. The last such cycle is the L3 hit cycle, so rdata_hold ends up holding the correct word.
  - When l3_ready = 1: next state = RESP.
- State RESP:
  - Pulse resp_valid[g].
  - resp_rdata = rdata_hold for a read, 0 for a write.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Next state = IDLE.
- Command and data outputs:
  - l3_addr, l3_read (= ~write flag), l3_write (= write flag) and l3_write_word are driven from the latched registers in ISSUE and WAIT and held stable there.
  - In IDLE and RESP these outputs are 0.
- Latency, req_ack to resp_valid:
  - L3 hit: 4 cycles.
  - Clean miss: 6 cycles.
  - Dirty miss: 7 cycles.
- Boundary conditions:
  - Requests arriving while busy wait; they are considered only in IDLE.
  - A requester that drops req_valid before being acked is not granted.
  - The just-served requester has lowest priority next arbitration.
  - A single active requester can be granted back-to-back, with a one-cycle IDLE gap between transactions.
  - Simultaneous requests from all requesters are served in rotation order.
  - The NUM_REQ-1 to 0 wrap of rr_ptr is required.
  - resp_err = 0 except as defined under Optional Feature.

Optional Feature:
L3_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with l3_ready still 0, go to RESP with resp_err = 1 and resp_rdata = 0, then continue normally.
  - A timeout does not reset the L3.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - resp_err is tied to 0.

Test Plan:
- Single read hit: requester 1 reads 0x0000_0040 on a preloaded line holding 0xDEAD_BEEF at that word -> req_ack[1] at cycle 0; resp_valid[1] at cycle 4; resp_rdata = 0xDEAD_BEEF; l3_valid high for exactly one cycle.
- Write then read: requester 0 writes 0x1234_5678 to 0x100, then reads 0x100 -> second response resp_rdata = 0x1234_5678; the write's response has resp_rdata = 0.
- Contention: all 4 req_valid asserted at once from reset -> grant order 0,1,2,3; then holding req 2 and 0 high gives 0 then 2.
- Miss latency: read of a clean-missing address -> resp at 6 cycles after ack; dirty-victim miss -> resp at 7 cycles; l3_addr stable across all WAIT cycles.
- Reset in WAIT: assert reset during WAIT -> all outputs 0 the same cycle (async); no resp_valid afterwards; next grant starts from requester 0.
- (L3_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8) stub L3 with l3_ready stuck at 0 -> resp_valid with resp_err = 1 after 8 WAIT cycles; arbiter returns to IDLE.
